// File: rtl/pred_pkg.sv
// Shared types and helpers for the branch-prediction counter table update path.
package pred_pkg;

  localparam int ADDR_W    = 64;
  localparam int CNT_W     = 2;
  localparam int PRT_DEPTH = 1024;
  localparam int IDX_W     = $clog2(PRT_DEPTH);
  localparam int BRCOM_N   = 2;

  typedef logic [IDX_W-1:0] pred_idx_t;
  typedef logic [CNT_W-1:0] pred_cnt_t;

  typedef struct packed {
    pred_idx_t idx;
    logic      taken;
  } upd_ent_t;

  localparam pred_cnt_t PRED_CNT_WNT = pred_cnt_t'((1 << (CNT_W - 1)) - 1);

  // Instructions are word aligned, so the two lowest address bits carry no information.
  function automatic pred_idx_t pred_index(input logic [ADDR_W-1:0] addr);
    return pred_idx_t'(addr >> 2);
  endfunction

  function automatic pred_cnt_t sat_inc(input pred_cnt_t c);
    return (&c) ? c : c + pred_cnt_t'(1);
  endfunction

  function automatic pred_cnt_t sat_dec(input pred_cnt_t c);
    return (c == '0) ? c : c - pred_cnt_t'(1);
  endfunction

endpackage

// File: rtl/pred_upd_fifo.sv
// Circular update queue: up to LANES writes per cycle (packed in lane order), one read.
module pred_upd_fifo
  import pred_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int LANES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [LANES-1:0]       push,
  input  upd_ent_t               ent [LANES],
  input  logic                   pop,
  output upd_ent_t               head,
  output logic [$clog2(DEPTH):0] occ
);

  localparam int PW = $clog2(DEPTH);

  upd_ent_t        mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [PW:0]     push_cnt;
  logic [PW-1:0]   slot [LANES];

  // Accepted lanes land in consecutive slots so lane 0 is always served first.
  always_comb begin
    push_cnt = '0;
    for (int i = 0; i < LANES; i++) begin
      slot[i]  = wr_ptr + push_cnt[PW-1:0];
      push_cnt = push_cnt + (PW+1)'(push[i]);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (push[i]) mem[slot[i]] <= ent[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      wr_ptr <= wr_ptr + push_cnt[PW-1:0];
      rd_ptr <= rd_ptr + PW'(pop);
      occ    <= occ + push_cnt - (PW+1)'(pop);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/pred_upd_sched.sv
// Serialises committed branch outcomes into the counter table's single port as a
// read-modify-write pipeline; sweeps the table to weakly-not-taken after reset.
module pred_upd_sched
  import pred_pkg::*;
#(
  parameter int ADDR     = ADDR_W,
  parameter int CNTW     = CNT_W,
  parameter int PRT_D    = PRT_DEPTH,
  parameter int SIMBRCOM = BRCOM_N,
  parameter int UQ_D     = 8,
  localparam int IDXW    = $clog2(PRT_D)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush_,
  input  logic [SIMBRCOM-1:0]      br_commit_,
  input  logic [SIMBRCOM*ADDR-1:0] br_com_addr,
  input  logic [SIMBRCOM-1:0]      br_taken_,
  output logic                     busy,
  output logic                     ovf,
  output logic                     tbl_rd_,
  output logic [IDXW-1:0]          tbl_rd_idx,
  input  logic [CNTW-1:0]          tbl_rd_cnt,
  output logic                     tbl_we_,
  output logic [IDXW-1:0]          tbl_wr_idx,
  output logic [CNTW-1:0]          tbl_wr_cnt
);

  localparam int OW = $clog2(UQ_D) + 1;
  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]    state;
  pred_idx_t     sweep_idx;
  logic [OW-1:0] occ;
  logic [OW-1:0] free_cnt;
  logic [OW-1:0] fit_cnt;
  logic [SIMBRCOM-1:0] accept;
  logic          drop;
  upd_ent_t      ents [SIMBRCOM];
  upd_ent_t      head;
  logic          vld_p0;
  logic          vld_p1;
  upd_ent_t      ent_p1;
  logic          fwd_vld;
  pred_idx_t     fwd_idx;
  pred_cnt_t     fwd_cnt;
  pred_cnt_t     cur_cnt;
  pred_cnt_t     new_cnt;
  logic          init_wr;
  logic          unused_ok;

  // Flush is ignored on purpose: committed outcomes are architectural.
  assign unused_ok = ^{flush_, br_com_addr};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_INIT;
      sweep_idx <= '0;
    end else if (state == ST_INIT) begin
      sweep_idx <= sweep_idx + pred_idx_t'(1);
      if (sweep_idx == pred_idx_t'(PRT_D - 1)) state <= ST_RUN;
    end
  end

  assign free_cnt = OW'(UQ_D) - occ;
  assign busy     = (state == ST_INIT) || (free_cnt < OW'(SIMBRCOM));

  // Lanes are admitted in order while registered free space lasts; the rest are lost.
  always_comb begin
    fit_cnt = '0;
    accept  = '0;
    drop    = 1'b0;
    for (int i = 0; i < SIMBRCOM; i++) begin
      ents[i].idx   = pred_index(br_com_addr[i*ADDR +: ADDR]);
      ents[i].taken = ~br_taken_[i];
      if (!br_commit_[i]) begin
        if (fit_cnt < free_cnt) begin
          accept[i] = 1'b1;
          fit_cnt   = fit_cnt + OW'(1);
        end else begin
          drop = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     ovf <= 1'b0;
    else if (drop) ovf <= 1'b1;
  end

  pred_upd_fifo #(
    .DEPTH (UQ_D),
    .LANES (SIMBRCOM)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (accept),
    .ent   (ents),
    .pop   (vld_p0),
    .head  (head),
    .occ   (occ)
  );

  // Stage R (p0): pop head and issue the table read.
  assign vld_p0     = (state == ST_RUN) && (occ != '0);
  assign tbl_rd_    = ~vld_p0;
  assign tbl_rd_idx = vld_p0 ? head.idx : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) vld_p1 <= 1'b0;
    else       vld_p1 <= vld_p0;
  end

  always_ff @(posedge clk) ent_p1 <= head;

  // Stage W (p1): the table returns old data when the previous cycle wrote the same entry.
  assign cur_cnt = (fwd_vld && fwd_idx == ent_p1.idx) ? fwd_cnt : tbl_rd_cnt;
  assign new_cnt = ent_p1.taken ? sat_inc(cur_cnt) : sat_dec(cur_cnt);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) fwd_vld <= 1'b0;
    else       fwd_vld <= vld_p1;
  end

  always_ff @(posedge clk) begin
    fwd_idx <= ent_p1.idx;
    fwd_cnt <= new_cnt;
  end

  assign init_wr    = (state == ST_INIT) && !reset;
  assign tbl_we_    = ~(init_wr || vld_p1);
  assign tbl_wr_idx = init_wr ? sweep_idx : (vld_p1 ? ent_p1.idx : '0);
  assign tbl_wr_cnt = init_wr ? PRED_CNT_WNT : (vld_p1 ? new_cnt : '0);

endmodule

// File: tb/tb_pred_upd_sched.sv
// Directed bench for pred_upd_sched: init sweep, RMW updates, forwarding, saturation, backpressure, reset.
module tb_pred_upd_sched;

  logic         clk = 1'b0;
  logic         reset;
  logic         flush_;
  logic [1:0]   br_commit_;
  logic [127:0] br_com_addr;
  logic [1:0]   br_taken_;
  logic         busy;
  logic         ovf;
  logic         tbl_rd_;
  logic [9:0]   tbl_rd_idx;
  logic [1:0]   tbl_rd_cnt;
  logic         tbl_we_;
  logic [9:0]   tbl_wr_idx;
  logic [1:0]   tbl_wr_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int wr_mon = 0;
  logic mon_en = 1'b0;

  always #5 clk = ~clk;

  pred_upd_sched dut (
    .clk         (clk),
    .reset       (reset),
    .flush_      (flush_),
    .br_commit_  (br_commit_),
    .br_com_addr (br_com_addr),
    .br_taken_   (br_taken_),
    .busy        (busy),
    .ovf         (ovf),
    .tbl_rd_     (tbl_rd_),
    .tbl_rd_idx  (tbl_rd_idx),
    .tbl_rd_cnt  (tbl_rd_cnt),
    .tbl_we_     (tbl_we_),
    .tbl_wr_idx  (tbl_wr_idx),
    .tbl_wr_cnt  (tbl_wr_cnt)
  );

  always @(posedge clk) begin
    if (mon_en && !tbl_we_) wr_mon <= wr_mon + 1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic commit(input logic [1:0] act, input logic [63:0] a0, input logic [63:0] a1,
                        input logic [1:0] tk);
    br_commit_  = ~act;
    br_com_addr = {a1, a0};
    br_taken_   = ~tk;
  endtask

  task automatic idle();
    br_commit_ = 2'b11;
    br_taken_  = 2'b11;
  endtask

  // Entered at the first sweep cycle; leaves at the sample point of the first RUN cycle.
  task automatic sweep_check(input string tag);
    int bad = 0;
    for (int i = 0; i < 1024; i++) begin
      if (tbl_we_ !== 1'b0 || tbl_wr_idx !== 10'(i) || tbl_wr_cnt !== 2'd1 || busy !== 1'b1)
        bad++;
      cyc();
      settle();
    end
    chk({tag, "_sweep_bad_cycles"}, bad, 0);
    chk({tag, "_run_busy"}, busy, 1'b0);
    chk({tag, "_run_we"}, tbl_we_, 1'b1);
    chk({tag, "_run_rd"}, tbl_rd_, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int k;
    reset       = 1'b1;
    flush_      = 1'b1;
    br_com_addr = '0;
    tbl_rd_cnt  = '0;
    idle();
    cyc(); cyc(); settle();
    chk("rst_busy", busy, 1'b1);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_rd", tbl_rd_, 1'b1);
    chk("rst_we", tbl_we_, 1'b1);
    chk("rst_rd_idx", tbl_rd_idx, 10'd0);
    chk("rst_wr_idx", tbl_wr_idx, 10'd0);
    chk("rst_wr_cnt", tbl_wr_cnt, 2'd0);

    // Test 1: init sweep
    cyc(); reset = 1'b0; settle();
    chk("t1_first_we", tbl_we_, 1'b0);
    chk("t1_first_idx", tbl_wr_idx, 10'd0);
    sweep_check("t1");

    // Test 2: single taken commit
    cyc(); commit(2'b01, 64'hdeadbeef, 64'h0, 2'b01); settle();
    chk("t2_t0_rd", tbl_rd_, 1'b1);
    cyc(); idle(); settle();
    chk("t2_t1_rd", tbl_rd_, 1'b0);
    chk("t2_t1_rd_idx", tbl_rd_idx, 10'h3BB);
    chk("t2_t1_we", tbl_we_, 1'b1);
    cyc(); tbl_rd_cnt = 2'd1; settle();
    chk("t2_t2_we", tbl_we_, 1'b0);
    chk("t2_t2_wr_idx", tbl_wr_idx, 10'h3BB);
    chk("t2_t2_wr_cnt", tbl_wr_cnt, 2'd2);
    chk("t2_t2_rd", tbl_rd_, 1'b1);
    cyc(); settle();
    chk("t2_t3_we", tbl_we_, 1'b1);

    // Test 3: two commits to the same entry, second needs forwarding; flush_ held low
    cyc(); flush_ = 1'b0; commit(2'b11, 64'hdeadbeef, 64'hdeadbeef, 2'b11); settle();
    cyc(); idle(); settle();
    chk("t3_t1_rd", tbl_rd_, 1'b0);
    chk("t3_t1_rd_idx", tbl_rd_idx, 10'h3BB);
    cyc(); tbl_rd_cnt = 2'd1; settle();
    chk("t3_t2_we", tbl_we_, 1'b0);
    chk("t3_t2_wr_idx", tbl_wr_idx, 10'h3BB);
    chk("t3_t2_wr_cnt", tbl_wr_cnt, 2'd2);
    chk("t3_t2_rd", tbl_rd_, 1'b0);
    chk("t3_t2_rd_idx", tbl_rd_idx, 10'h3BB);
    cyc(); tbl_rd_cnt = 2'd1; settle();
    chk("t3_t3_we", tbl_we_, 1'b0);
    chk("t3_t3_wr_cnt_fwd", tbl_wr_cnt, 2'd3);
    cyc(); flush_ = 1'b1; settle();
    chk("t3_t4_we", tbl_we_, 1'b1);
    chk("t3_t4_rd", tbl_rd_, 1'b1);

    // Test 4: saturation at both ends, then mid-range steps; upper address bits ignored
    cyc(); commit(2'b11, 64'hFFFF_0000_0000_0100, 64'h204, 2'b01); settle();
    cyc(); idle(); settle();
    chk("t4a_rd_idx0", tbl_rd_idx, 10'h040);
    cyc(); tbl_rd_cnt = 2'd3; settle();
    chk("t4a_wr_idx0", tbl_wr_idx, 10'h040);
    chk("t4a_inc_sat", tbl_wr_cnt, 2'd3);
    chk("t4a_rd_idx1", tbl_rd_idx, 10'h081);
    cyc(); tbl_rd_cnt = 2'd0; settle();
    chk("t4a_wr_idx1", tbl_wr_idx, 10'h081);
    chk("t4a_dec_sat", tbl_wr_cnt, 2'd0);
    cyc(); commit(2'b11, 64'h208, 64'h30C, 2'b10); settle();
    cyc(); idle(); settle();
    cyc(); tbl_rd_cnt = 2'd2; settle();
    chk("t4b_wr_idx0", tbl_wr_idx, 10'h082);
    chk("t4b_dec", tbl_wr_cnt, 2'd1);
    cyc(); tbl_rd_cnt = 2'd0; settle();
    chk("t4b_wr_idx1", tbl_wr_idx, 10'h0C3);
    chk("t4b_inc", tbl_wr_cnt, 2'd1);
    cyc(); settle();

    // Test 5: back-to-back dual commits until busy, one commit while busy, drain
    cyc(); settle();
    n = 0;
    mon_en = 1'b1;
    for (int j = 0; j < 20; j++) begin
      cyc();
      if (busy) break;
      commit(2'b11, 64'h400 + 64'(j * 16), 64'h408 + 64'(j * 16), 2'b11);
      n++;
    end
    chk("t5_commit_cycles", n, 6);
    commit(2'b11, 64'h800, 64'h808, 2'b11); settle();
    chk("t5_busy", busy, 1'b1);
    chk("t5_ovf_before", ovf, 1'b0);
    cyc(); idle(); settle();
    chk("t5_ovf_set", ovf, 1'b1);
    chk("t5_busy_still", busy, 1'b1);
    k = 0;
    while (!(tbl_rd_ && tbl_we_) && k < 30) begin
      cyc(); settle();
      k++;
    end
    chk("t5_drain_in_time", k < 30, 1'b1);
    chk("t5_drain_cycles", k, 8);
    mon_en = 1'b0;
    chk("t5_writes", wr_mon, 13);
    chk("t5_busy_after", busy, 1'b0);
    chk("t5_ovf_sticky", ovf, 1'b1);

    // Test 6a: reset in the middle of the sweep
    cyc(); reset = 1'b1; settle();
    chk("t6a_rst_we", tbl_we_, 1'b1);
    chk("t6a_rst_busy", busy, 1'b1);
    chk("t6a_rst_ovf", ovf, 1'b0);
    cyc(); reset = 1'b0; settle();
    chk("t6a_first_idx", tbl_wr_idx, 10'd0);
    for (int i = 0; i < 500; i++) cyc();
    settle();
    chk("t6a_mid_idx", tbl_wr_idx, 10'd500);
    reset = 1'b1; #1;
    chk("t6a_mid_rst_we", tbl_we_, 1'b1);
    cyc(); reset = 1'b0; settle();
    chk("t6a_restart_we", tbl_we_, 1'b0);
    chk("t6a_restart_idx", tbl_wr_idx, 10'd0);
    sweep_check("t6a");

    // Test 6b: reset while an update sits in the read stage
    cyc(); commit(2'b01, 64'hdeadbeef, 64'h0, 2'b01); settle();
    cyc(); idle(); settle();
    chk("t6b_rd_active", tbl_rd_, 1'b0);
    reset = 1'b1; #1;
    chk("t6b_rst_we", tbl_we_, 1'b1);
    chk("t6b_rst_rd", tbl_rd_, 1'b1);
    cyc(); reset = 1'b0; tbl_rd_cnt = 2'd1; settle();
    chk("t6b_restart_we", tbl_we_, 1'b0);
    chk("t6b_restart_idx", tbl_wr_idx, 10'd0);
    chk("t6b_restart_cnt", tbl_wr_cnt, 2'd1);
    sweep_check("t6b");
    k = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(); settle();
      if (!tbl_we_ || !tbl_rd_) k++;
    end
    chk("t6b_no_stale_access", k, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
